// File: rtl/seg7_scan_to_bcd.sv
// Recovers BCD digits from a multiplexed active-high 7-segment bus and assembles frames.
// Optional SEG7_BLANK_EN: all-dark pattern decodes to 4'hF and counts as valid.
module seg7_scan_to_bcd #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] bcd,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [NDIG-1:0]   err_mask
);
  localparam int SW = NDIG + 7;
  localparam logic [7:0] STAB = 8'(STABLE_CYC);

  logic [SW-1:0]          cur, prev;
  logic [7:0]             run, run_nxt;
  logic                   onehot, same, accept, complete;
  logic [3:0]             dval;
  logic                   dinv;
  logic [NDIG-1:0]        seen, seen_nxt;
  logic [NDIG-1:0][3:0]   stg_val, stg_val_nxt;
  logic [NDIG-1:0]        stg_inv, stg_inv_nxt;

  assign cur    = {dig_sel, seg};
  assign same   = (cur == prev);
  assign onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);

  always_comb begin
    dinv = 1'b0;
    dval = 4'hE;
    case (seg)
      7'b0111111: dval = 4'd0;
      7'b0000110: dval = 4'd1;
      7'b1011011: dval = 4'd2;
      7'b1001111: dval = 4'd3;
      7'b1100110: dval = 4'd4;
      7'b1101101: dval = 4'd5;
      7'b1111101: dval = 4'd6;
      7'b0000111: dval = 4'd7;
      7'b1111111: dval = 4'd8;
      7'b1101111: dval = 4'd9;
`ifdef SEG7_BLANK_EN
      7'b0000000: dval = 4'hF;
`endif
      default:    dinv = 1'b1;
    endcase
  end

  // Run length of the current one-hot sample; a saturated run means it was already accepted.
  always_comb begin
    run_nxt = 8'd0;
    if (onehot) begin
      if (!same)            run_nxt = 8'd1;
      else if (run >= STAB) run_nxt = STAB;
      else                  run_nxt = run + 8'd1;
    end
  end

  assign accept   = onehot && (run_nxt == STAB) && !(same && run == STAB);
  assign seen_nxt = seen | (accept ? dig_sel : '0);
  assign complete = accept && (&seen_nxt);

  for (genvar i = 0; i < NDIG; i++) begin : g_slot
    always_comb begin
      stg_val_nxt[i] = stg_val[i];
      stg_inv_nxt[i] = stg_inv[i];
      if (accept && dig_sel[i]) begin
        stg_val_nxt[i] = dval;
        stg_inv_nxt[i] = dinv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev        <= '0;
      run         <= 8'd0;
      seen        <= '0;
      stg_val     <= '0;
      stg_inv     <= '0;
      bcd         <= '0;
      err_mask    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      prev        <= cur;
      run         <= run_nxt;
      stg_val     <= stg_val_nxt;
      stg_inv     <= stg_inv_nxt;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (complete) begin
        bcd         <= stg_val_nxt;
        err_mask    <= stg_inv_nxt;
        frame_valid <= ~|stg_inv_nxt;
        frame_err   <= |stg_inv_nxt;
        seen        <= '0;
      end else begin
        seen        <= seen_nxt;
      end
    end
  end
endmodule
